uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmit word port (uart_tx_reg / uart_tx_en of the UART top) between
//  NUM_REQ requesters. Round-robin grant, one 32-bit word per grant.
//  Tracks transmit-FIFO occupancy with a credit counter and a drain timer. The UART top does not
//  export the FIFO full flag, so this block paces writes itself and never overflows the FIFO.
//  Sits between the user logic blocks and uart_module in the same sys_clk domain.
// PARAMETERS
//  NUM_REQ      4       number of requesters, >=1
//  CLK_FRE      50      system clock, MHz
//  BPS          115200  UART baud rate
//  CREDITS      16      TX FIFO depth, in 32-bit words
//  GUARD_CYCLES 64      extra cycles per word added to the drain estimate (margin)
//  LOCK_MAX     8       max consecutive words one locked requester may issue (UART_ARB_LOCK_EN only)
// PORTS
//  sys_clk      in   1          system clock
//  rst          in   1          asynchronous reset, active-high
//  req_valid    in   NUM_REQ    requester i has a word pending
//  req_data     in   32*NUM_REQ word of requester i, at bits [32*i+31:32*i]
//  req_ready    out  NUM_REQ    one-cycle accept pulse to requester i
//  req_lock     in   NUM_REQ    keep grant for the next word (only with UART_ARB_LOCK_EN)
//  uart_tx_reg  out  32         word to the UART top
//  uart_tx_en   out  1          one-cycle write strobe to the UART top
//  grant_id     out  $clog2(NUM_REQ)|1  index of the last granted requester
//  credits      out  $clog2(CREDITS+1)  free FIFO words (estimated)
//  busy         out  1          FSM not in IDLE, or credits < CREDITS
// BEHAVIOUR
//  Reset (async, rst=1):
//   - all outputs 0; credits=CREDITS; rr_ptr=0; drain timer=0; lock count=0; state IDLE.
//  FSM IDLE -> ISSUE -> GAP -> IDLE:
//   - IDLE: if |req_valid and credits>0, pick the first valid index scanning rr_ptr, rr_ptr+1, ...
//     mod NUM_REQ. Register its data into uart_tx_reg, register grant_id, go to ISSUE.
//     With credits==0 the FSM stays in IDLE and nothing is accepted.
//   - ISSUE (1 cycle): uart_tx_en=1 and req_ready[grant_id]=1 in the same cycle; credits decrement.
//     rr_ptr <= grant_id+1 mod NUM_REQ.
//   - GAP (1 cycle): uart_tx_en=0, then back to IDLE. Max rate is 1 word per 3 cycles.
//  Latency: req_valid high at edge t -> uart_tx_en and req_ready high in cycle t+1.
//  Requester handshake: hold req_valid and req_data stable until req_ready is seen. Dropping
//   req_valid earlier is a protocol violation; a word already latched is still sent.
//  uart_tx_reg holds its value outside ISSUE. Downstream samples it only when uart_tx_en=1.
//  Credits / drain:
//   - WORD_CYCLES = (CLK_FRE*1_000_000/BPS)*40 + GUARD_CYCLES (4 bytes x 10 bits). Integer
//     division; the counter is wide enough for WORD_CYCLES-1.
//   - The timer counts only while credits<CREDITS. At WORD_CYCLES-1 it returns one credit and
//     restarts at 0. At credits==CREDITS the timer is held at 0.
//   - Issue and credit return in the same cycle: net credits unchanged.
//   - credits never exceeds CREDITS and never wraps below 0.
//  NUM_REQ=1: fixed grant, rr_ptr stays 0, grant_id is 1 bit and always 0.
//  Reset mid-operation: all state is discarded and credits go back to CREDITS. rst must also
//   reset the UART top so the FIFO is empty again.
// CONFIGURATION
//  Macro UART_ARB_LOCK_EN:
//   - Defined: req_lock is used. If req_lock[grant_id]=1 during ISSUE and the lock count is below
//     LOCK_MAX-1, rr_ptr is held at grant_id and the lock count increments. The locked requester
//     therefore wins the next IDLE arbitration if it is valid. Otherwise rr_ptr advances normally
//     and the lock count clears. The lock count also clears when the requester is not valid in IDLE.
//   - Undefined: req_lock is ignored (port kept, unused); pure round-robin.
// STRUCTURE
//  Package uart_pkg:
//   - typedef enum {IDLE, ISSUE, GAP} uart_arb_state_t;
//   - function word_cycles(clk_fre, bps, guard);
//   - localparam BITS_PER_BYTE=10, BYTES_PER_WORD=4.
//  Sub-module uart_credit_timer: owns the credit counter and the drain timer. Inputs issue and
//   reset; outputs credits and has_credit.
//  Top: FSM, round-robin picker, lock logic.
// TESTING
//  1. Reset: rst=1 mid-ISSUE -> uart_tx_en=0, req_ready=0, credits=16, busy=0 on the same cycle.
//  2. Single requester: req_valid[2]=1, data 0xDEADBEEF -> uart_tx_en and req_ready[2] high one
//     cycle later, uart_tx_reg=0xDEADBEEF, credits=15, grant_id=2.
//  3. Round-robin: all 4 valid continuously -> grant order 0,1,2,3,0; uart_tx_en every 3rd cycle.
//  4. Credit exhaustion: 16 words back-to-back -> 17th not accepted, credits=0. With CLK_FRE=50,
//     BPS=115200, WORD_CYCLES=434*40+64=17424: one credit returns 17424 cycles after the first
//     issue, then the 17th word is sent.
//  5. Simultaneous: issue in the cycle the timer expires -> credits unchanged; timer restarts at 0.
//  6. UART_ARB_LOCK_EN, LOCK_MAX=8: req 1 locked and valid, req 0 valid -> 8 words from req 1,
//     then req 0 granted. Without the macro -> 1,0,1,0 alternation.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Word pacing is derived from the baud rate: 4 bytes of 10 line bits each, plus a guard margin.
package uart_pkg;

  localparam int BITS_PER_BYTE  = 10;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } uart_arb_state_t;

  function automatic int word_cycles(input int clk_fre, input int bps, input int guard);
    return ((clk_fre * 1_000_000) / bps) * BITS_PER_BYTE * BYTES_PER_WORD + guard;
  endfunction

endpackage

// File: rtl/uart_credit_timer.sv
// Estimated TX FIFO occupancy: one credit per free word, and a drain timer that
// hands one credit back every WORD_CYCLES cycles while the FIFO is not empty.
module uart_credit_timer
  import uart_pkg::*;
#(
  parameter int  CREDITS     = 16,
  parameter int  WORD_CYCLES = 17424,
  localparam int CW          = $clog2(CREDITS + 1),
  localparam int TW          = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  output logic [CW-1:0] credits,
  output logic          has_credit
);

  logic [CW-1:0] credits_q, credits_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ret;
  logic          take;

  always_comb begin
    ret       = 1'b0;
    timer_d   = timer_q;
    credits_d = credits_q;
    take      = issue && (credits_q != '0);

    // With a full set of credits the FIFO is assumed empty, so nothing is draining.
    if (credits_q < CW'(CREDITS)) begin
      if (timer_q == TW'(WORD_CYCLES - 1)) begin
        ret     = 1'b1;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else begin
      timer_d = '0;
    end

    case ({take, ret})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= CW'(CREDITS);
      timer_q   <= '0;
    end else begin
      credits_q <= credits_d;
      timer_q   <= timer_d;
    end
  end

  assign credits    = credits_q;
  assign has_credit = (credits_q != '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit word port, paced by a FIFO credit estimate.
// Optional macro UART_ARB_LOCK_EN lets a requester keep the grant for up to LOCK_MAX words.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  CLK_FRE      = 50,
  parameter int  BPS          = 115200,
  parameter int  CREDITS      = 16,
  parameter int  GUARD_CYCLES = 64,
  parameter int  LOCK_MAX     = 8,
  localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW           = $clog2(CREDITS + 1)
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [31:0]          uart_tx_reg,
  output logic                 uart_tx_en,
  output logic [IDW-1:0]       grant_id,
  output logic [CW-1:0]        credits,
  output logic                 busy
);

  localparam int WORD_CYCLES = word_cycles(CLK_FRE, BPS, GUARD_CYCLES);

  uart_arb_state_t state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [31:0]     tx_reg_q, tx_reg_d;
  logic [IDW-1:0]  pick_idx;
  logic [IDW:0]    pick_sum;
  logic            pick_found;
  logic            issue;
  logic            has_credit;
  logic [CW-1:0]   credits_w;
  logic [31:0]     req_word [NUM_REQ];

`ifdef UART_ARB_LOCK_EN
  localparam int LW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock ^ (LOCK_MAX > 0);
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data[32*i +: 32];
  end

  function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] id);
    if (id == IDW'(NUM_REQ - 1)) return '0;
    return id + IDW'(1);
  endfunction

  // First valid requester at or after rr_ptr, wrapping around once.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pick_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (pick_sum >= (IDW+1)'(NUM_REQ)) pick_sum = pick_sum - (IDW+1)'(NUM_REQ);
      if (!pick_found && req_valid[pick_sum[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = pick_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_reg_d   = tx_reg_q;
    issue      = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef UART_ARB_LOCK_EN
        if (!req_valid[rr_ptr_q]) lock_cnt_d = '0;
`endif
        if (pick_found && has_credit) begin
          grant_id_d = pick_idx;
          tx_reg_d   = req_word[pick_idx];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
        state_d = GAP;
`ifdef UART_ARB_LOCK_EN
        // Holding rr_ptr on the current grant makes it win the next arbitration if still valid.
        if (req_lock[grant_id_q] && (lock_cnt_q < LW'(LOCK_MAX - 1))) begin
          rr_ptr_d   = grant_id_q;
          lock_cnt_d = lock_cnt_q + LW'(1);
        end else begin
          rr_ptr_d   = ptr_after(grant_id_q);
          lock_cnt_d = '0;
        end
`else
        rr_ptr_d = ptr_after(grant_id_q);
`endif
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_reg_q   <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      tx_reg_q   <= tx_reg_d;
`ifdef UART_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  uart_credit_timer #(
    .CREDITS     (CREDITS),
    .WORD_CYCLES (WORD_CYCLES)
  ) u_credit (
    .clk        (sys_clk),
    .rst        (rst),
    .issue      (issue),
    .credits    (credits_w),
    .has_credit (has_credit)
  );

  always_comb begin
    req_ready = '0;
    if (state_q == ISSUE) req_ready[grant_id_q] = 1'b1;
  end

  assign uart_tx_en  = (state_q == ISSUE);
  assign uart_tx_reg = tx_reg_q;
  assign grant_id    = grant_id_q;
  assign credits     = credits_w;
  assign busy        = (state_q != IDLE) || (credits_w < CW'(CREDITS));

endmodule
